oled_cmd_fifo: RTL and testbench
================================

Name: oled_cmd_fifo

Overview:
- Elastic buffer between data_streamer (producer) and ssd1306_driver (consumer) in the frequency counter display path.
- Absorbs bursts of glyph bytes and sync requests from the streamer while the driver is busy shifting SPI.
- Replays them to the driver one at a time, following the driver's strobe/ready handshake.
- Decouples the streamer's refresh burst from the driver's per-byte SPI time.

Parameters:
- DEPTH, 16, number of entries; power of two, >= 2
- DATA_W, 8, data byte width
- LVL_W, $clog2(DEPTH)+1, width of the occupancy count (derived, not overridden)

Ports:
- clk_in  in  1  single clock, same as the driver (clk_ref_in domain)
- reset_in  in  1  asynchronous, active-high reset
- data_in  in  DATA_W  byte from streamer, qualified by write_stb_in
- write_stb_in  in  1  one-cycle pulse: queue data_in as a data entry
- sync_stb_in  in  1  one-cycle pulse: queue a sync (home to 0,0) entry
- ready_out  out  1  FIFO can accept a strobe this cycle
- oled_data_out  out  DATA_W  byte to driver, valid with oled_write_stb_out
- oled_write_stb_out  out  1  one-cycle data strobe to driver
- oled_sync_stb_out  out  1  one-cycle sync strobe to driver
- oled_ready_in  in  1  driver ready_out
- level_out  out  LVL_W  current occupancy
- empty_out  out  1  occupancy == 0

Behaviour:
- Entry format: {is_sync, byte}; sync entries store byte = 0.
- Reset values (async, while reset_in high):
  - all pointers, count and FSM cleared; FSM in S_IDLE
  - oled_data_out = 0, both strobes = 0
  - level_out = 0, empty_out = 1, ready_out = 0
  - ready_out = !full_q && !reset_in; rises the first clock after release
- Push: accepted when a strobe is high and ready_out is high. Entry is visible at the head next cycle.
- Both strobes in the same cycle: protocol error. Only the sync entry is queued and the byte is dropped.
- Strobe while ready_out is low: dropped silently, no state change.
- count <= count + push - pop, all registered.
  - Push while full is impossible; pop frees a slot and ready_out rises the next cycle.
  - Pop decisions use the registered count, so an empty FIFO cannot pass a same-cycle push through.
- Consumer FSM, states S_IDLE, S_ISSUE, S_GUARD:
  - S_IDLE: if count != 0 and oled_ready_in, pop the head into the output register and go to S_ISSUE.
  - S_ISSUE: drive exactly one strobe high for one cycle (sync strobe if is_sync, else write strobe), then go to S_GUARD.
  - S_GUARD: one cycle with oled_ready_in ignored, covering the driver's one-cycle ready deassert latency; then S_IDLE.
- Latency: push at cycle N into an empty FIFO with the driver ready gives the strobe at cycle N+2.
- Maximum throughput: one entry per 3 cycles.
- oled_data_out holds its value after a strobe until the next issue. It is not cleared.
- Ordering is strict FIFO; data and sync entries are never reordered.
- Pointers wrap modulo DEPTH; count distinguishes full from empty.
- oled_ready_in dropping while in S_IDLE: stall, no entry lost.
- reset_in mid-operation: all queued entries discarded; a strobe in flight is cut off asynchronously.

Optional Feature:
- Macro: OLED_CMD_FIFO_STATS_EN
- With the macro, extra ports:
  - overflow_out (1): sticky; set by any strobe dropped while ready_out is low, or by a double-strobe error; cleared only by reset.
  - high_water_out (LVL_W): maximum count seen since reset.
- Without the macro: these ports and their logic do not exist; core behaviour is identical.

Decomposition:
- Package oled_pkg:
  - oled_entry_t struct {logic is_sync; logic [7:0] byte}
  - e_fifo_state enum {S_IDLE, S_ISSUE, S_GUARD}
- One sub-module, oled_fifo_mem: DEPTH x entry storage, with write port (we, waddr, wdata) and registered read port (raddr, rdata). No reset on storage.
- Pointers, count and FSM stay in oled_cmd_fifo.

Test Plan:
- Basic write: reset, driver ready held 1, write_stb 0xA5 at cycle 10 -> oled_write_stb_out high at cycle 12 with oled_data_out = 0xA5; level_out goes 1 then 0.
- Order: push 0x11, sync, 0x22 back-to-back -> driver sees write 0x11, sync, write 0x22, strobes spaced 3 cycles apart.
- Full: driver ready held 0, push 17 bytes 0x00..0x10 -> ready_out low after the 16th; 0x10 dropped; level_out = 16. Release ready -> exactly 0x00..0x0F delivered.
- Double strobe: write_stb (0x55) and sync_stb in the same cycle -> single sync strobe, no write; with STATS_EN, overflow_out = 1.
- Mid-burst reset: 8 entries queued, reset_in pulsed during S_ISSUE -> strobe drops immediately; level_out = 0, empty_out = 1; no further strobes after release.
- Backpressure: driver drops ready for 40 cycles mid-stream -> no strobes during the stall, no loss, resume in order; with STATS_EN, high_water_out equals the peak count.

Source files
------------

// File: rtl/oled_pkg.sv
// Shared types for the OLED command FIFO.
//   oled_entry_t : one queued command, {is_sync, byte}; sync entries carry byte = 0
//   e_fifo_state : consumer FSM states (S_IDLE -> S_ISSUE -> S_GUARD -> S_IDLE)
package oled_pkg;

  localparam int ENTRY_BYTE_W = 8;

  typedef struct packed {
    logic                    is_sync;
    logic [ENTRY_BYTE_W-1:0] data;
  } oled_entry_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_GUARD = 2'd2
  } e_fifo_state;

endpackage

// File: rtl/oled_fifo_mem.sv
// DEPTH x WIDTH entry storage for the OLED command FIFO.
// Ports:
//   clk   : clock
//   we    : write enable, stores wdata at waddr
//   waddr : write address
//   wdata : write data
//   raddr : read address, sampled every clock
//   rdata : registered read data (write-first when raddr == waddr)
// Storage has no reset; the owner tracks validity with its own count.
module oled_fifo_mem #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 9,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write port plus registered read. A write to the address being read is
  // forwarded so an entry pushed into an empty FIFO is at the head next cycle.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (we && (waddr == raddr)) begin
      rdata <= wdata;
    end else begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/oled_cmd_fifo.sv
// Elastic command buffer between data_streamer and ssd1306_driver.
// Queues data bytes and sync requests, then replays them one per handshake,
// at most one entry every 3 cycles (S_IDLE pop, S_ISSUE strobe, S_GUARD).
// Ports:
//   clk_in, reset_in          : clock, asynchronous active-high reset
//   data_in, write_stb_in     : queue a data entry
//   sync_stb_in               : queue a sync entry (wins over a same-cycle write)
//   ready_out                 : FIFO accepts a strobe this cycle
//   oled_data_out             : byte to driver, held until the next issue
//   oled_write_stb_out        : one-cycle data strobe
//   oled_sync_stb_out         : one-cycle sync strobe
//   oled_ready_in             : driver ready
//   level_out, empty_out      : occupancy and empty flag
// Optional (macro OLED_CMD_FIFO_STATS_EN):
//   overflow_out              : sticky dropped-strobe / double-strobe flag
//   high_water_out            : peak occupancy since reset
module oled_cmd_fifo
  import oled_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 8,
  localparam int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic              clk_in,
  input  logic              reset_in,
  input  logic [DATA_W-1:0] data_in,
  input  logic              write_stb_in,
  input  logic              sync_stb_in,
  output logic              ready_out,
  output logic [DATA_W-1:0] oled_data_out,
  output logic              oled_write_stb_out,
  output logic              oled_sync_stb_out,
  input  logic              oled_ready_in,
  output logic [LVL_W-1:0]  level_out,
  output logic              empty_out
`ifdef OLED_CMD_FIFO_STATS_EN
  ,
  output logic              overflow_out,
  output logic [LVL_W-1:0]  high_water_out
`endif
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  rd_ptr_next;
  logic [LVL_W-1:0]  count;
  logic [LVL_W-1:0]  count_next;
  logic              push;
  logic              pop;
  logic [DATA_W:0]   wr_entry;
  logic [DATA_W:0]   head;
  e_fifo_state       state;

  // Push/pop decisions; pop looks only at the registered count so a push in
  // the same cycle can never fall through an empty FIFO.
  always_comb begin
    push        = ready_out && (write_stb_in || sync_stb_in);
    wr_entry    = sync_stb_in ? {1'b1, {DATA_W{1'b0}}} : {1'b0, data_in};
    pop         = (state == S_IDLE) && (count != '0) && oled_ready_in;
    rd_ptr_next = pop ? rd_ptr + PTR_W'(1) : rd_ptr;
    count_next  = count + LVL_W'(push) - LVL_W'(pop);
  end

  // The read address is the next head so rdata always shows the current head.
  oled_fifo_mem #(
    .DEPTH (DEPTH),
    .WIDTH (DATA_W + 1)
  ) u_mem (
    .clk   (clk_in),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (wr_entry),
    .raddr (rd_ptr_next),
    .rdata (head)
  );

  // Pointers, occupancy and the flags derived from it.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      ready_out <= 1'b0;
      empty_out <= 1'b1;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      rd_ptr    <= rd_ptr_next;
      count     <= count_next;
      ready_out <= (count_next != LVL_W'(DEPTH));
      empty_out <= (count_next == '0);
    end
  end

  assign level_out = count;

  // Consumer FSM with registered strobes and output byte.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      state              <= S_IDLE;
      oled_data_out      <= '0;
      oled_write_stb_out <= 1'b0;
      oled_sync_stb_out  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pop) begin
            oled_data_out      <= head[DATA_W-1:0];
            oled_write_stb_out <= ~head[DATA_W];
            oled_sync_stb_out  <= head[DATA_W];
            state              <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          oled_write_stb_out <= 1'b0;
          oled_sync_stb_out  <= 1'b0;
          state              <= S_GUARD;
        end
        // Driver ready is ignored here: it takes one cycle to deassert.
        S_GUARD: begin
          state <= S_IDLE;
        end
        default: begin
          oled_write_stb_out <= 1'b0;
          oled_sync_stb_out  <= 1'b0;
          state              <= S_IDLE;
        end
      endcase
    end
  end

`ifdef OLED_CMD_FIFO_STATS_EN
  // Sticky error flag and peak occupancy tracking.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      overflow_out   <= 1'b0;
      high_water_out <= '0;
    end else begin
      if (((write_stb_in || sync_stb_in) && !ready_out) ||
          (write_stb_in && sync_stb_in)) begin
        overflow_out <= 1'b1;
      end
      if (count_next > high_water_out) begin
        high_water_out <= count_next;
      end
    end
  end
`endif

endmodule

// File: tb/tb_oled_cmd_fifo.sv
// Self-checking bench for oled_cmd_fifo: a per-cycle vector table followed by
// hand-written multi-cycle sequences (ordering, full, mid-burst reset, stall).
module tb_oled_cmd_fifo;

  localparam int LVL_W = 5;

  logic             clk_in = 1'b0;
  logic             reset_in = 1'b1;
  logic [7:0]       data_in = 8'h00;
  logic             write_stb_in = 1'b0;
  logic             sync_stb_in = 1'b0;
  logic             ready_out;
  logic [7:0]       oled_data_out;
  logic             oled_write_stb_out;
  logic             oled_sync_stb_out;
  logic             oled_ready_in = 1'b1;
  logic [LVL_W-1:0] level_out;
  logic             empty_out;
`ifdef OLED_CMD_FIFO_STATS_EN
  logic             overflow_out;
  logic [LVL_W-1:0] high_water_out;
`endif

  oled_cmd_fifo #(.DEPTH(16), .DATA_W(8)) dut (
    .clk_in             (clk_in),
    .reset_in           (reset_in),
    .data_in            (data_in),
    .write_stb_in       (write_stb_in),
    .sync_stb_in        (sync_stb_in),
    .ready_out          (ready_out),
    .oled_data_out      (oled_data_out),
    .oled_write_stb_out (oled_write_stb_out),
    .oled_sync_stb_out  (oled_sync_stb_out),
    .oled_ready_in      (oled_ready_in),
    .level_out          (level_out),
    .empty_out          (empty_out)
`ifdef OLED_CMD_FIFO_STATS_EN
    ,
    .overflow_out       (overflow_out),
    .high_water_out     (high_water_out)
`endif
  );

  always #5 clk_in = ~clk_in;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic       is_sync;
    logic [7:0] data;
    int         cyc;
  } cap_t;
  cap_t cap[$];

  always @(posedge clk_in) cyc <= cyc + 1;

  // Strobe monitor: records every strobe seen by the driver.
  always @(negedge clk_in) begin
    if (oled_write_stb_out || oled_sync_stb_out) begin
      cap.push_back('{oled_sync_stb_out, oled_data_out, cyc});
      total++;
      if (oled_write_stb_out && oled_sync_stb_out) begin
        bad++;
        $display("FAIL both_strobes cyc=%0d both write and sync high", cyc);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic do_reset(input bit check_vals);
    write_stb_in  = 1'b0;
    sync_stb_in   = 1'b0;
    reset_in      = 1'b1;
    repeat (2) tick();
    if (check_vals) begin
      chk("rst_level", 32'(level_out), 32'd0);
      chk("rst_empty", 32'(empty_out), 32'd1);
      chk("rst_ready", 32'(ready_out), 32'd0);
      chk("rst_wstb", 32'(oled_write_stb_out), 32'd0);
      chk("rst_sstb", 32'(oled_sync_stb_out), 32'd0);
      chk("rst_data", 32'(oled_data_out), 32'd0);
`ifdef OLED_CMD_FIFO_STATS_EN
      chk("rst_ovf", 32'(overflow_out), 32'd0);
      chk("rst_hw", 32'(high_water_out), 32'd0);
`endif
    end
    reset_in = 1'b0;
    tick();
    if (check_vals) chk("ready_after_release", 32'(ready_out), 32'd1);
    tick();
  endtask

  task automatic push(input logic [7:0] d, input logic s);
    data_in      = d;
    write_stb_in = ~s;
    sync_stb_in  = s;
    tick();
    write_stb_in = 1'b0;
    sync_stb_in  = 1'b0;
  endtask

  typedef struct {
    logic       wr;
    logic       sy;
    logic [7:0] d;
    logic       rdy;
    logic [4:0] lvl;
    logic       emp;
    logic       ws;
    logic       ss;
    logic [7:0] od;
  } vec_t;

  vec_t vt[17];

  initial begin
    int push_cyc;
    int seen;
    int qsz;

    // wr sy data rdy | level empty wstb sstb data_out (after the edge)
    vt[0]  = '{1'b1, 1'b0, 8'hA5, 1'b1, 5'd1, 1'b0, 1'b0, 1'b0, 8'h00};
    vt[1]  = '{1'b0, 1'b0, 8'h00, 1'b1, 5'd0, 1'b1, 1'b1, 1'b0, 8'hA5};
    vt[2]  = '{1'b0, 1'b0, 8'h00, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 8'hA5};
    vt[3]  = '{1'b0, 1'b0, 8'h00, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 8'hA5};
    vt[4]  = '{1'b1, 1'b1, 8'h55, 1'b1, 5'd1, 1'b0, 1'b0, 1'b0, 8'hA5};
    vt[5]  = '{1'b0, 1'b0, 8'h00, 1'b1, 5'd0, 1'b1, 1'b0, 1'b1, 8'h00};
    vt[6]  = '{1'b0, 1'b0, 8'h00, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 8'h00};
    vt[7]  = '{1'b1, 1'b0, 8'h3C, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0, 8'h00};
    vt[8]  = '{1'b0, 1'b0, 8'h00, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0, 8'h00};
    vt[9]  = '{1'b0, 1'b0, 8'h00, 1'b1, 5'd0, 1'b1, 1'b1, 1'b0, 8'h3C};
    vt[10] = '{1'b0, 1'b0, 8'h00, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 8'h3C};
    vt[11] = '{1'b1, 1'b0, 8'h01, 1'b1, 5'd1, 1'b0, 1'b0, 1'b0, 8'h3C};
    vt[12] = '{1'b1, 1'b0, 8'h02, 1'b1, 5'd1, 1'b0, 1'b1, 1'b0, 8'h01};
    vt[13] = '{1'b0, 1'b0, 8'h00, 1'b1, 5'd1, 1'b0, 1'b0, 1'b0, 8'h01};
    vt[14] = '{1'b0, 1'b0, 8'h00, 1'b1, 5'd1, 1'b0, 1'b0, 1'b0, 8'h01};
    vt[15] = '{1'b0, 1'b0, 8'h00, 1'b1, 5'd0, 1'b1, 1'b1, 1'b0, 8'h02};
    vt[16] = '{1'b0, 1'b0, 8'h00, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 8'h02};

    do_reset(1'b1);

    // Vector table: basic write, double strobe, stall, push+pop same cycle.
    for (int i = 0; i < 17; i++) begin
      write_stb_in  = vt[i].wr;
      sync_stb_in   = vt[i].sy;
      data_in       = vt[i].d;
      oled_ready_in = vt[i].rdy;
      tick();
      chk($sformatf("v%0d_level", i), 32'(level_out), 32'(vt[i].lvl));
      chk($sformatf("v%0d_empty", i), 32'(empty_out), 32'(vt[i].emp));
      chk($sformatf("v%0d_ready", i), 32'(ready_out), 32'd1);
      chk($sformatf("v%0d_wstb", i), 32'(oled_write_stb_out), 32'(vt[i].ws));
      chk($sformatf("v%0d_sstb", i), 32'(oled_sync_stb_out), 32'(vt[i].ss));
      chk($sformatf("v%0d_data", i), 32'(oled_data_out), 32'(vt[i].od));
    end
    write_stb_in = 1'b0;
`ifdef OLED_CMD_FIFO_STATS_EN
    chk("dbl_overflow", 32'(overflow_out), 32'd1);
`endif

    // Ordering and latency: 0x11, sync, 0x22 back-to-back.
    do_reset(1'b0);
    cap.delete();
    oled_ready_in = 1'b1;
    push_cyc = cyc;
    push(8'h11, 1'b0);
    push(8'h00, 1'b1);
    push(8'h22, 1'b0);
    repeat (15) tick();
    chk("ord_count", 32'(cap.size()), 32'd3);
    if (cap.size() == 3) begin
      chk("ord0_sync", 32'(cap[0].is_sync), 32'd0);
      chk("ord0_data", 32'(cap[0].data), 32'h11);
      chk("ord1_sync", 32'(cap[1].is_sync), 32'd1);
      chk("ord1_data", 32'(cap[1].data), 32'h00);
      chk("ord2_sync", 32'(cap[2].is_sync), 32'd0);
      chk("ord2_data", 32'(cap[2].data), 32'h22);
      chk("ord_latency", 32'(cap[0].cyc - push_cyc), 32'd2);
      chk("ord_gap01", 32'(cap[1].cyc - cap[0].cyc), 32'd3);
      chk("ord_gap12", 32'(cap[2].cyc - cap[1].cyc), 32'd3);
    end

    // Full: 17 pushes with the driver stalled; the 17th is dropped.
    do_reset(1'b0);
    cap.delete();
    oled_ready_in = 1'b0;
    for (int i = 0; i < 16; i++) push(8'(i), 1'b0);
    chk("full_ready", 32'(ready_out), 32'd0);
    chk("full_level16", 32'(level_out), 32'd16);
    push(8'h10, 1'b0);
    chk("full_level_after_drop", 32'(level_out), 32'd16);
`ifdef OLED_CMD_FIFO_STATS_EN
    chk("full_overflow", 32'(overflow_out), 32'd1);
    chk("full_hw", 32'(high_water_out), 32'd16);
`endif
    oled_ready_in = 1'b1;
    repeat (60) tick();
    chk("full_delivered", 32'(cap.size()), 32'd16);
    for (int i = 0; i < 16 && i < cap.size(); i++) begin
      chk($sformatf("full_item%0d", i), 32'({cap[i].is_sync, cap[i].data}), 32'(i));
    end
    chk("full_drain_empty", 32'(empty_out), 32'd1);

    // Mid-burst reset while a strobe is in flight.
    do_reset(1'b0);
    oled_ready_in = 1'b0;
    for (int i = 0; i < 8; i++) push(8'h80 + 8'(i), 1'b0);
    oled_ready_in = 1'b1;
    seen = 0;
    for (int i = 0; i < 20 && seen == 0; i++) begin
      tick();
      if (oled_write_stb_out) seen = 1;
    end
    chk("mid_strobe_seen", 32'(seen), 32'd1);
    reset_in = 1'b1;
    #1;
    chk("mid_rst_wstb", 32'(oled_write_stb_out), 32'd0);
    chk("mid_rst_level", 32'(level_out), 32'd0);
    chk("mid_rst_empty", 32'(empty_out), 32'd1);
    tick();
    reset_in = 1'b0;
    cap.delete();
    repeat (20) tick();
    chk("mid_no_strobes", 32'(cap.size()), 32'd0);

    // Backpressure: driver ready drops while pushes continue, held 40 cycles.
    do_reset(1'b0);
    cap.delete();
    oled_ready_in = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (i == 6) oled_ready_in = 1'b0;
      push(8'h40 + 8'(i), 1'b0);
    end
    qsz = cap.size();
    chk("bp_pre_stall_count", 32'(qsz), 32'd2);
    chk("bp_level", 32'(level_out), 32'd10);
    repeat (40) tick();
    chk("bp_no_strobe_in_stall", 32'(cap.size()), 32'(qsz));
`ifdef OLED_CMD_FIFO_STATS_EN
    chk("bp_high_water", 32'(high_water_out), 32'd10);
`endif
    oled_ready_in = 1'b1;
    repeat (40) tick();
    chk("bp_delivered", 32'(cap.size()), 32'd12);
    for (int i = 0; i < 12 && i < cap.size(); i++) begin
      chk($sformatf("bp_item%0d", i), 32'({cap[i].is_sync, cap[i].data}), 32'h40 + 32'(i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
